score_display_ctrl: RTL

SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

---
 rtl/score_display_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/score_display_ctrl.sv
// Score keeper with a sequential double-dabble BCD converter and a blinking 7-segment display.
// Optional macro SCORE_LZB_EN blanks leading zero digits on seg (bcd is unaffected).
module score_display_ctrl #(
  parameter int SCORE_W    = 7,
  parameter int NUM_DIGITS = 2,
  parameter int MAX_SCORE  = 99,
  parameter int BLINK_DIV  = 100
) (
  input  logic                    clk,
  input  logic                    nRst,
  input  logic                    goodColl,
  input  logic                    badColl,
  output logic [SCORE_W-1:0]      dispScore,
  output logic                    isGameComplete,
  output logic                    isGameOver,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic                    busy
);

  localparam int BCD_W   = 4 * NUM_DIGITS;
  localparam int CNT_W   = $clog2(SCORE_W);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  logic                     r_good_d, r_bad_d;
  logic [SCORE_W-1:0]       r_score;
  logic                     r_complete, r_over;
  logic                     w_good_edge, w_bad_edge;
  logic [SCORE_W-1:0]       w_inc;

  state_t                   r_state, w_state_nxt;
  logic [SCORE_W-1:0]       r_bin, r_cap, r_last;
  logic [BCD_W-1:0]         r_scratch, r_bcd;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_busy;
  logic                     w_start;
  logic [BCD_W+SCORE_W-1:0] w_dd;

  logic [BLINK_W-1:0]       r_blink_cnt;
  logic                     r_phase;
  logic [NUM_DIGITS-1:0]    w_blank;
  logic                     w_blank_all;
  logic [7*NUM_DIGITS-1:0]  w_seg;

  assign w_good_edge = goodColl & ~r_good_d;
  assign w_bad_edge  = badColl & ~r_bad_d;
  assign w_inc       = r_score + SCORE_W'(1);

  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_good_d   <= 1'b0;
      r_bad_d    <= 1'b0;
      r_score    <= '0;
      r_complete <= 1'b0;
      r_over     <= 1'b0;
    end else begin
      r_good_d <= goodColl;
      r_bad_d  <= badColl;
      // badColl takes priority; once a flag is up the score is frozen
      if (!r_over && !r_complete) begin
        if (w_bad_edge) begin
          r_over <= 1'b1;
        end else if (w_good_edge) begin
          r_score <= w_inc;
          if (w_inc == SCORE_W'(MAX_SCORE)) r_complete <= 1'b1;
        end
      end
    end
  end

  assign w_start = (r_score != r_last);
  assign w_dd    = {dd_adjust(r_scratch), r_bin} << 1;

  always_ff @(posedge clk) begin
    if (!nRst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == CNT_W'(SCORE_W - 1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Working registers need no reset: they are always loaded on entry to SHIFT
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_start) begin
      r_bin     <= r_score;
      r_cap     <= r_score;
      r_scratch <= '0;
      r_cnt     <= '0;
    end else if (r_state == S_SHIFT) begin
      r_scratch <= w_dd[BCD_W+SCORE_W-1:SCORE_W];
      r_bin     <= w_dd[SCORE_W-1:0];
      r_cnt     <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_bcd  <= '0;
      r_last <= '0;
      r_busy <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:  if (w_start) r_busy <= 1'b1;
        S_DONE: begin
          r_bcd  <= r_scratch;
          r_last <= r_cap;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
    end
  end

`ifdef SCORE_LZB_EN
  logic w_lead;
  always_comb begin
    w_blank = '0;
    w_lead  = 1'b1;
    for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
      if (w_lead && (r_bcd[4*d +: 4] == 4'd0)) w_blank[d] = 1'b1;
      else                                     w_lead     = 1'b0;
    end
  end
`else
  assign w_blank = '0;
`endif

  assign w_blank_all = (r_over | r_complete) & ~r_phase;

  always_comb begin
    w_seg = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (!w_blank[d] && !w_blank_all) w_seg[7*d +: 7] = seg7(r_bcd[4*d +: 4]);
    end
  end

  assign dispScore      = r_score;
  assign isGameComplete = r_complete;
  assign isGameOver     = r_over;
  assign bcd            = r_bcd;
  assign seg            = w_seg;
  assign busy           = r_busy;

endmodule
